mmio_responder: RTL and testbench

MMIO_RESPONDER -- requirements
Module: mmio_responder

---
 rtl/mmio_pkg.sv | 51 +++++
 rtl/timer_unit.sv | 63 ++++++
 rtl/mmio_responder.sv | 108 ++++++++++
 tb/tb_mmio_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared address map, RAM geometry and TCON bit positions for the MMIO responder.
package mmio_pkg;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam int          RAM_DEPTH = 256;
    localparam int          RAM_AW    = 8;

    localparam logic [31:0] MMIO_BASE   = 32'h4000_0000;
    localparam logic [4:0]  OFF_TH      = 5'h00;
    localparam logic [4:0]  OFF_TL      = 5'h04;
    localparam logic [4:0]  OFF_TCON    = 5'h08;
    localparam logic [4:0]  OFF_LEDS    = 5'h0C;
    localparam logic [4:0]  OFF_DIGI    = 5'h10;
    localparam logic [4:0]  OFF_SYSTICK = 5'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LEDS,
        SEL_DIGI,
        SEL_SYSTICK
    } sel_e;

    // Byte-lane bits [1:0] never take part in the decode.
    function automatic sel_e decodeAddr(input logic [31:0] addr);
        sel_e sel;
        sel = SEL_NONE;
        if (addr[31:10] == RAM_BASE[31:10]) begin
            sel = SEL_RAM;
        end else if (addr[31:5] == MMIO_BASE[31:5]) begin
            case ({addr[4:2], 2'b00})
                OFF_TH:      sel = SEL_TH;
                OFF_TL:      sel = SEL_TL;
                OFF_TCON:    sel = SEL_TCON;
                OFF_LEDS:    sel = SEL_LEDS;
                OFF_DIGI:    sel = SEL_DIGI;
                OFF_SYSTICK: sel = SEL_SYSTICK;
                default:     sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/timer_unit.sv
// Reloading 32-bit timer: TH holds the reload value, TL counts up, TCON = {status, irq enable, enable}.
module timer_unit
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wrTh,
    input  logic        i_wrTl,
    input  logic        i_wrTcon,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_th,
    output logic [31:0] o_tl,
    output logic [2:0]  o_tcon,
    output logic        o_irq
);

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic        w_overflow;
    logic        w_setStatus;

    assign w_overflow  = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);
    assign w_setStatus = w_overflow && r_tcon[TCON_IE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th <= '0;
        end else if (i_wrTh) begin
            r_th <= i_wdata;
        end
    end

    // A CPU store to TL beats both the reload and the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tl <= '0;
        end else if (i_wrTl) begin
            r_tl <= i_wdata;
        end else if (w_overflow) begin
            r_tl <= r_th;
        end else if (r_tcon[TCON_EN]) begin
            r_tl <= r_tl + 32'd1;
        end
    end

    // An overflow in the same cycle as a TCON store still sets status, so no interrupt is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcon <= '0;
        end else if (i_wrTcon) begin
            r_tcon <= {i_wdata[TCON_IS] | w_setStatus, i_wdata[TCON_IE], i_wdata[TCON_EN]};
        end else if (w_setStatus) begin
            r_tcon[TCON_IS] <= 1'b1;
        end
    end

    assign o_th   = r_th;
    assign o_tl   = r_tl;
    assign o_tcon = r_tcon;
    assign o_irq  = r_tcon[TCON_IS];

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped responder: word RAM, timer, LED/digit registers and a bus error flag.
// Defining MMIO_SYSTICK_EN adds a free-running systick counter at 0x40000014.
module mmio_responder
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Mem_data,
    output logic        irq,
    output logic [7:0]  leds,
    output logic [11:0] digi,
    output logic        bus_err
);

    logic [31:0]       r_ram [0:RAM_DEPTH-1];
    logic [7:0]        r_leds;
    logic [11:0]       r_digi;
    logic              r_busErr;
    sel_e              w_sel;
    logic [RAM_AW-1:0] w_ramIdx;
    logic [31:0]       w_th;
    logic [31:0]       w_tl;
    logic [2:0]        w_tcon;
    logic [31:0]       w_systick;
    logic              w_unused;

    assign w_sel    = decodeAddr(Address);
    assign w_ramIdx = Address[RAM_AW+1:2];
    assign w_unused = ^Address[1:0];

    timer_unit u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_wrTh   (MemWrite && (w_sel == SEL_TH)),
        .i_wrTl   (MemWrite && (w_sel == SEL_TL)),
        .i_wrTcon (MemWrite && (w_sel == SEL_TCON)),
        .i_wdata  (Write_data),
        .o_th     (w_th),
        .o_tl     (w_tl),
        .o_tcon   (w_tcon),
        .o_irq    (irq)
    );

    // RAM keeps its contents across reset, so it has no reset branch at all.
    always_ff @(posedge clk) begin
        if (MemWrite && (w_sel == SEL_RAM)) begin
            r_ram[w_ramIdx] <= Write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leds   <= '0;
            r_digi   <= '0;
            r_busErr <= 1'b0;
        end else begin
            if (MemWrite && (w_sel == SEL_LEDS)) begin
                r_leds <= Write_data[7:0];
            end
            if (MemWrite && (w_sel == SEL_DIGI)) begin
                r_digi <= Write_data[11:0];
            end
            r_busErr <= (MemRead || MemWrite) && (w_sel == SEL_NONE);
        end
    end

`ifdef MMIO_SYSTICK_EN
    logic [31:0] r_systick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end

    assign w_systick = r_systick;
`else
    assign w_systick = '0;
`endif

    // Reads are purely combinational, so a read+write cycle returns the pre-write value.
    always_comb begin
        Mem_data = '0;
        if (MemRead) begin
            case (w_sel)
                SEL_RAM:     Mem_data = r_ram[w_ramIdx];
                SEL_TH:      Mem_data = w_th;
                SEL_TL:      Mem_data = w_tl;
                SEL_TCON:    Mem_data = {29'd0, w_tcon};
                SEL_LEDS:    Mem_data = {24'd0, r_leds};
                SEL_DIGI:    Mem_data = {20'd0, r_digi};
                SEL_SYSTICK: Mem_data = w_systick;
                default:     Mem_data = '0;
            endcase
        end
    end

    assign leds    = r_leds;
    assign digi    = r_digi;
    assign bus_err = r_busErr;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: each driven cycle queues its expected outputs, a negedge monitor checks them.
module tb_mmio_responder;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Mem_data;
    logic        irq;
    logic [7:0]  leds;
    logic [11:0] digi;
    logic        bus_err;

    typedef struct {
        string       name;
        bit          chkData;
        logic [31:0] expData;
        bit          chkIrq;
        logic        expIrq;
        bit          chkBus;
        logic        expBus;
        bit          chkLeds;
        logic [7:0]  expLeds;
        bit          chkDigi;
        logic [11:0] expDigi;
    } exp_t;

    exp_t expQ[$];
    int   testsRun  = 0;
    int   testsFail = 0;

    bit          pIrqV  = 0;
    logic        pIrq   = 0;
    bit          pBusV  = 0;
    logic        pBus   = 0;
    bit          pLedsV = 0;
    logic [7:0]  pLeds  = 0;
    bit          pDigiV = 0;
    logic [11:0] pDigi  = 0;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LEDS = 32'h4000_000C;
    localparam logic [31:0] A_DIGI = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;
    localparam logic [31:0] A_BAD  = 32'h2000_0000;
    localparam logic [31:0] A_BADW = 32'h4000_001C;

    mmio_responder dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Mem_data   (Mem_data),
        .irq        (irq),
        .leds       (leds),
        .digi       (digi),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Side-output expectations are armed here and folded into the next queued cycle.
    task automatic expectIrq(input logic v);  pIrqV = 1;  pIrq = v;  endtask
    task automatic expectBus(input logic v);  pBusV = 1;  pBus = v;  endtask
    task automatic expectLeds(input logic [7:0] v);  pLedsV = 1; pLeds = v; endtask
    task automatic expectDigi(input logic [11:0] v); pDigiV = 1; pDigi = v; endtask

    task automatic applyStimulus(input string name, input logic rst, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit chkData, input logic [31:0] expData);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rst;
        MemRead    = rd;
        MemWrite   = wr;
        Address    = addr;
        Write_data = wdata;
        e.name    = name;
        e.chkData = chkData;
        e.expData = expData;
        e.chkIrq  = pIrqV;  e.expIrq  = pIrq;
        e.chkBus  = pBusV;  e.expBus  = pBus;
        e.chkLeds = pLedsV; e.expLeds = pLeds;
        e.chkDigi = pDigiV; e.expDigi = pDigi;
        pIrqV = 0; pBusV = 0; pLedsV = 0; pDigiV = 0;
        expQ.push_back(e);
    endtask

    task automatic rdOp(input string name, input logic [31:0] addr, input logic [31:0] exp);
        applyStimulus(name, 1'b0, 1'b1, 1'b0, addr, 32'd0, 1'b1, exp);
    endtask

    task automatic wrOp(input string name, input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(name, 1'b0, 1'b0, 1'b1, addr, data, 1'b0, 32'd0);
    endtask

    task automatic idleOp(input string name);
        applyStimulus(name, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic rstRdOp(input string name, input logic [31:0] addr, input logic [31:0] exp);
        applyStimulus(name, 1'b1, 1'b1, 1'b0, addr, 32'd0, 1'b1, exp);
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.chkData) begin
            testsRun++;
            if (Mem_data !== e.expData) begin
                testsFail++;
                $display("[TB] FAIL %s Mem_data got=%08h want=%08h", e.name, Mem_data, e.expData);
            end
        end
        if (e.chkIrq) begin
            testsRun++;
            if (irq !== e.expIrq) begin
                testsFail++;
                $display("[TB] FAIL %s irq got=%0b want=%0b", e.name, irq, e.expIrq);
            end
        end
        if (e.chkBus) begin
            testsRun++;
            if (bus_err !== e.expBus) begin
                testsFail++;
                $display("[TB] FAIL %s bus_err got=%0b want=%0b", e.name, bus_err, e.expBus);
            end
        end
        if (e.chkLeds) begin
            testsRun++;
            if (leds !== e.expLeds) begin
                testsFail++;
                $display("[TB] FAIL %s leds got=%02h want=%02h", e.name, leds, e.expLeds);
            end
        end
        if (e.chkDigi) begin
            testsRun++;
            if (digi !== e.expDigi) begin
                testsFail++;
                $display("[TB] FAIL %s digi got=%03h want=%03h", e.name, digi, e.expDigi);
            end
        end
    endtask

    // Monitor: one queued expectation per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; Write_data = '0;

        // Reset state
        expectIrq(0); expectBus(0); expectLeds(8'h00); expectDigi(12'h000);
        applyStimulus("rst_hold", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        rdOp("rst_tcon", A_TCON, 32'd0);
        rdOp("rst_tl", A_TL, 32'd0);

        // RAM, including a read-during-write cycle
        wrOp("ram_w2", 32'h0000_0008, 32'hCAFE_F00D);
        wrOp("ram_w1", 32'h0000_0004, 32'h1234_5678);
        rdOp("ram_r1_offset", 32'h0000_0006, 32'h1234_5678);
        rdOp("ram_r2", 32'h0000_0008, 32'hCAFE_F00D);
        wrOp("ram_w3", 32'h0000_000C, 32'h1111_1111);
        applyStimulus("ram_rw3_prewrite", 1'b0, 1'b1, 1'b1, 32'h0000_000C, 32'h2222_2222, 1'b1, 32'h1111_1111);
        rdOp("ram_r3_post", 32'h0000_000C, 32'h2222_2222);

        // Narrow registers
        wrOp("leds_w", A_LEDS, 32'hFFFF_FFA5);
        expectLeds(8'hA5);
        rdOp("leds_r", A_LEDS, 32'h0000_00A5);
        wrOp("digi_w", A_DIGI, 32'hFFFF_F123);
        expectDigi(12'h123);
        rdOp("digi_r", A_DIGI, 32'h0000_0123);

        // Unmapped accesses
        expectBus(0);
        rdOp("bad_rd", A_BAD, 32'd0);
        expectBus(1);
        idleOp("bad_rd_err");
        expectBus(0);
        idleOp("bad_rd_err_drop");
        expectBus(0);
        wrOp("bad_wr", A_BADW, 32'hFFFF_FFFF);
        expectBus(1); expectLeds(8'hA5); expectDigi(12'h123);
        idleOp("bad_wr_err");
        expectBus(0);
        rdOp("bad_wr_th", A_TH, 32'd0);
        rdOp("bad_wr_tcon", A_TCON, 32'd0);
`ifdef MMIO_SYSTICK_EN
        rdOp("systick_rd", A_TICK, 32'd20);
`else
        rdOp("systick_rd", A_TICK, 32'd0);
`endif
        expectBus(0);
        idleOp("systick_no_err");

        // Timer overflow and reload
        wrOp("tmr_th", A_TH, 32'hFFFF_FFFC);
        wrOp("tmr_tl", A_TL, 32'hFFFF_FFFE);
        wrOp("tmr_tcon", A_TCON, 32'd3);
        expectIrq(0);
        rdOp("tmr_tl_fe", A_TL, 32'hFFFF_FFFE);
        expectIrq(0);
        rdOp("tmr_tl_ff", A_TL, 32'hFFFF_FFFF);
        expectIrq(1);
        rdOp("tmr_tl_reload", A_TL, 32'hFFFF_FFFC);
        rdOp("tmr_tcon_7", A_TCON, 32'd7);
        wrOp("tmr_stop", A_TCON, 32'd0);
        expectIrq(0);
        rdOp("tmr_tcon_0", A_TCON, 32'd0);

        // Clear attempt coinciding with overflow
        wrOp("cc_tl", A_TL, 32'hFFFF_FFFE);
        wrOp("cc_tcon", A_TCON, 32'd3);
        expectIrq(0);
        rdOp("cc_tl_fe", A_TL, 32'hFFFF_FFFE);
        expectIrq(0);
        wrOp("cc_coincide", A_TCON, 32'd3);
        expectIrq(1);
        rdOp("cc_tcon_7", A_TCON, 32'd7);
        expectIrq(1);
        wrOp("cc_clear", A_TCON, 32'd3);
        expectIrq(0);
        wrOp("cc_stop", A_TCON, 32'd0);
        expectIrq(0);
        rdOp("cc_tcon_0", A_TCON, 32'd0);
        rdOp("cc_tl_held", A_TL, 32'hFFFF_FFFF);

        // Reset in the middle of a count
        wrOp("mr_tl", A_TL, 32'h0000_0010);
        wrOp("mr_tcon", A_TCON, 32'd3);
        rdOp("mr_tl_10", A_TL, 32'h0000_0010);
        expectLeds(8'hA5);
        rdOp("mr_bad", A_BAD, 32'd0);
        expectLeds(8'h00); expectIrq(0); expectBus(0);
        rstRdOp("mr_rst_tl", A_TL, 32'd0);
        rstRdOp("mr_rst_tcon", A_TCON, 32'd0);
        rstRdOp("mr_rst_ram", 32'h0000_0004, 32'h1234_5678);
        rdOp("mr_rel_tl", A_TL, 32'd0);
        expectIrq(0);
        rdOp("mr_tl_idle", A_TL, 32'd0);
        expectIrq(0); expectLeds(8'h00); expectDigi(12'h000);
        idleOp("mr_quiet");

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFail++;
            $display("[TB] FAIL scoreboard_drain pending=%0d want=0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
